// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire stream decoder.
//
// Samples the strip data line, measures each high pulse and turns it into a
// bit. Bits are assembled MSB-first into pixel words, each tagged with its
// index in the frame. A long low gap (latch) closes the frame and reports
// how many pixels arrived and whether anything went wrong.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   din          raw WS2812 data line (asynchronous to clk)
//   pixel_data   last decoded pixel, first-received bit in the MSB
//   pixel_index  index of pixel_data within the frame
//   pixel_valid  one-cycle strobe: pixel_data/pixel_index are new
//   frame_done   one-cycle strobe at latch detection
//   frame_count  pixels received in the frame just closed (held)
//   frame_err    error flag for the frame just closed (held)
//   busy         high while a frame is being decoded (HIGH or LOW state)
module ws2812_rx #(
    parameter int T_MIN_HIGH     = 15,
    parameter int T_THRESH       = 60,
    parameter int T_MAX_HIGH     = 110,
    parameter int T_RESET        = 5000,
    parameter int PX_NUM         = 52,
    parameter int IDX_WIDTH      = 6,
    parameter int BITS_PER_PIXEL = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel_data,
    output logic [IDX_WIDTH-1:0]      pixel_index,
    output logic                      pixel_valid,
    output logic                      frame_done,
    output logic [IDX_WIDTH:0]        frame_count,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int CW = 13;
    localparam int BW = $clog2(BITS_PER_PIXEL + 1);
    localparam int PW = IDX_WIDTH + 1;

    localparam logic [CW-1:0] T_MIN_C    = CW'(T_MIN_HIGH);
    localparam logic [CW-1:0] T_THRESH_C = CW'(T_THRESH);
    localparam logic [CW-1:0] T_MAX_C    = CW'(T_MAX_HIGH);
    localparam logic [CW-1:0] T_RESET_C  = CW'(T_RESET);
    localparam logic [BW-1:0] BIT_LAST_C = BW'(BITS_PER_PIXEL - 1);
    localparam logic [PW-1:0] PX_NUM_C   = PW'(PX_NUM);
    localparam logic [PW-1:0] PX_SAT_C   = PW'(PX_NUM + 1);

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        IDLE       = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic                      din_meta_q, din_meta_d;
    logic                      din_s_q, din_s_d;
    logic                      din_d_q, din_d_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]             pix_cnt_q, pix_cnt_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic                      err_q, err_d;
    logic [BITS_PER_PIXEL-1:0] pixel_data_q, pixel_data_d;
    logic [IDX_WIDTH-1:0]      pixel_index_q, pixel_index_d;
    logic                      pixel_valid_q, pixel_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic [PW-1:0]             frame_count_q, frame_count_d;
    logic                      frame_err_q, frame_err_d;
    logic                      busy_q, busy_d;

    logic                      rise_s, fall_s, bit_val_s, bad_pulse_s;

    // Synchronizer, edge detect and level-duration counter.
    always_comb begin
        din_meta_d = din;
        din_s_d    = din_meta_q;
        din_d_d    = din_s_q;
        rise_s     = din_s_q & ~din_d_q;
        fall_s     = ~din_s_q & din_d_q;
        // The edge cycle is already the first cycle of the new level, so the
        // count restarts at 1: at the fall, cnt_q equals the high time exactly.
        if (rise_s || fall_s) begin
            cnt_d = CW'(1);
        end else if (cnt_q == T_RESET_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        bit_val_s   = (cnt_q >= T_THRESH_C);
        bad_pulse_s = (cnt_q < T_MIN_C) || (cnt_q > T_MAX_C);
    end

    // Decoder state machine: next state, pixel assembly and frame bookkeeping.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        shift_d       = shift_q;
        err_d         = err_q;
        pixel_data_d  = pixel_data_q;
        pixel_index_d = pixel_index_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        frame_err_d   = frame_err_q;
        case (state_q)
            WAIT_LATCH: begin
                // Only a full latch-length low proves we are between frames.
                if (!din_s_q && !din_d_q && (cnt_q == T_RESET_C)) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LATCH;
                end
            end
            IDLE: begin
                if (rise_s) begin
                    state_d   = HIGH;
                    bit_cnt_d = {BW{1'b0}};
                    pix_cnt_d = {PW{1'b0}};
                    err_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (fall_s) begin
                    state_d = LOW;
                    if (bad_pulse_s) begin
                        // Glitch or stuck-high pulse: drop the partial pixel.
                        err_d     = 1'b1;
                        bit_cnt_d = {BW{1'b0}};
                    end else begin
                        shift_d = {shift_q[BITS_PER_PIXEL-2:0], bit_val_s};
                        if (bit_cnt_q == BIT_LAST_C) begin
                            bit_cnt_d = {BW{1'b0}};
                            if (pix_cnt_q < PX_NUM_C) begin
                                pixel_valid_d = 1'b1;
                                pixel_data_d  = shift_d;
                                pixel_index_d = pix_cnt_q[IDX_WIDTH-1:0];
                            end else begin
                                err_d = 1'b1;
                            end
                            // Saturates one past PX_NUM so overflow stays visible.
                            if (pix_cnt_q != PX_SAT_C) begin
                                pix_cnt_d = pix_cnt_q + PW'(1);
                            end else begin
                                pix_cnt_d = pix_cnt_q;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end else begin
                    state_d = HIGH;
                end
            end
            LOW: begin
                if (rise_s) begin
                    state_d = HIGH;
                end else if (cnt_q == T_RESET_C) begin
                    state_d       = IDLE;
                    frame_done_d  = 1'b1;
                    frame_count_d = (pix_cnt_q > PX_NUM_C) ? PX_NUM_C : pix_cnt_q;
                    frame_err_d   = err_q | (bit_cnt_q != {BW{1'b0}});
                end else begin
                    state_d = LOW;
                end
            end
            default: begin
                state_d = WAIT_LATCH;
            end
        endcase
        busy_d = (state_d == HIGH) || (state_d == LOW);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_LATCH;
            din_meta_q    <= 1'b0;
            din_s_q       <= 1'b0;
            din_d_q       <= 1'b0;
            cnt_q         <= {CW{1'b0}};
            bit_cnt_q     <= {BW{1'b0}};
            pix_cnt_q     <= {PW{1'b0}};
            shift_q       <= {BITS_PER_PIXEL{1'b0}};
            err_q         <= 1'b0;
            pixel_data_q  <= {BITS_PER_PIXEL{1'b0}};
            pixel_index_q <= {IDX_WIDTH{1'b0}};
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= {PW{1'b0}};
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            din_meta_q    <= din_meta_d;
            din_s_q       <= din_s_d;
            din_d_q       <= din_d_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            shift_q       <= shift_d;
            err_q         <= err_d;
            pixel_data_q  <= pixel_data_d;
            pixel_index_q <= pixel_index_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_index = pixel_index_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Testbench for ws2812_rx. Stimulus pushes expected pixels and frame
// results into queues; a monitor pops and compares on every strobe.
// The latch time is shortened to keep the run short.
module tb_ws2812_rx;

    localparam int TR = 500;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] pixel_data;
    logic [5:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [6:0]  frame_count;
    logic        frame_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [29:0] exp_px[$];   // {index, data}
    logic [7:0]  exp_fr[$];   // {count, err}

    ws2812_rx #(
        .T_MIN_HIGH(15), .T_THRESH(60), .T_MAX_HIGH(110), .T_RESET(TR),
        .PX_NUM(52), .IDX_WIDTH(6), .BITS_PER_PIXEL(24)
    ) dut (
        .clk(clk), .reset(reset), .din(din),
        .pixel_data(pixel_data), .pixel_index(pixel_index),
        .pixel_valid(pixel_valid), .frame_done(frame_done),
        .frame_count(frame_count), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every strobe against the head of its queue.
    always @(negedge clk) begin
        if (pixel_valid) begin
            if (exp_px.size() == 0) begin
                chk("unexpected_pixel_valid", {40'd0, pixel_index, pixel_data}, 64'd0);
            end else begin
                logic [29:0] e;
                e = exp_px.pop_front();
                chk("pixel_data", {40'd0, pixel_data}, {40'd0, e[23:0]});
                chk("pixel_index", {58'd0, pixel_index}, {58'd0, e[29:24]});
            end
        end
        if (frame_done) begin
            if (exp_fr.size() == 0) begin
                chk("unexpected_frame_done", {56'd0, frame_count, frame_err}, 64'd0);
            end else begin
                logic [7:0] f;
                f = exp_fr.pop_front();
                chk("frame_count", {57'd0, frame_count}, {57'd0, f[7:1]});
                chk("frame_err", {63'd0, frame_err}, {63'd0, f[0]});
            end
        end
    end

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Send the low n bits of v, MSB first.
    task automatic send_bits(input logic [23:0] v, input int n, input bit slow);
        for (int i = n - 1; i >= 0; i--) begin
            if (slow) begin
                if (v[i]) pulse(80, 45); else pulse(40, 85);
            end else begin
                if (v[i]) pulse(60, 2); else pulse(15, 2);
            end
        end
    endtask

    task automatic latch();
        din = 1'b0;
        repeat (TR + 12) @(negedge clk);
    endtask

    task automatic expect_px(input int idx, input logic [23:0] d);
        logic [5:0] i6;
        i6 = 6'(idx);
        exp_px.push_back({i6, d});
    endtask

    task automatic expect_fr(input int cnt, input logic err);
        logic [6:0] c7;
        c7 = 7'(cnt);
        exp_fr.push_back({c7, err});
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        // Reset held with din toggling: everything stays at zero.
        for (int k = 0; k < 8; k++) begin
            din = ~din;
            repeat (7) @(negedge clk);
            chk("reset_outputs",
                {23'd0, pixel_data, pixel_index, pixel_valid, frame_done, frame_count, frame_err, busy},
                64'd0);
        end
        // Release mid-stream with no prior latch: nothing may decode.
        din   = 1'b1;
        reset = 1'b0;
        send_bits(24'hFFFFFF, 24, 1'b1);
        send_bits(24'h1, 1, 1'b1);
        latch();
        chk("busy_after_wait_latch", {63'd0, busy}, 64'd0);

        // Single pixel at nominal timing.
        expect_px(0, 24'hA53C0F);
        expect_fr(1, 1'b0);
        send_bits(24'hA53C0F, 24, 1'b1);
        latch();

        // Boundary pulses 59/60/15/110 are all legal: bits 0,1,0,1.
        din = 1'b1;
        repeat (30) @(negedge clk);
        chk("busy_in_high", {63'd0, busy}, 64'd1);
        repeat (29) @(negedge clk);
        din = 1'b0;
        repeat (3) @(negedge clk);
        pulse(60, 3);
        pulse(15, 3);
        pulse(110, 3);
        expect_px(0, 24'h5ABCDE);
        expect_fr(1, 1'b0);
        send_bits(24'h0ABCDE, 20, 1'b0);
        latch();
        chk("busy_after_latch", {63'd0, busy}, 64'd0);

        // 14- and 111-cycle pulses are errors that discard the partial pixel.
        send_bits(24'h3FF, 10, 1'b0);
        pulse(14, 3);
        expect_px(0, 24'h123456);
        send_bits(24'h123456, 24, 1'b0);
        send_bits(24'h15, 5, 1'b0);
        pulse(111, 3);
        expect_px(1, 24'h00FF00);
        send_bits(24'h00FF00, 24, 1'b0);
        expect_fr(2, 1'b1);
        latch();

        // Full 52-pixel frame.
        for (int i = 0; i < 52; i++) begin
            logic [23:0] d;
            d = 24'(i * 32'h010203);
            expect_px(i, d);
            send_bits(d, 24, 1'b0);
        end
        expect_fr(52, 1'b0);
        latch();

        // 53 pixels: the 53rd is not strobed and flags an error.
        for (int i = 0; i < 53; i++) begin
            if (i < 52) expect_px(i, 24'h000000);
            send_bits(24'h000000, 24, 1'b0);
        end
        expect_fr(52, 1'b1);
        latch();

        // 10-cycle glitch inside pixel 3.
        expect_px(0, 24'h111111);
        send_bits(24'h111111, 24, 1'b0);
        expect_px(1, 24'h222222);
        send_bits(24'h222222, 24, 1'b0);
        expect_px(2, 24'h333333);
        send_bits(24'h333333, 24, 1'b0);
        send_bits(24'h44, 8, 1'b0);
        pulse(10, 3);
        expect_px(3, 24'h555555);
        send_bits(24'h555555, 24, 1'b0);
        expect_px(4, 24'h666666);
        send_bits(24'h666666, 24, 1'b0);
        expect_fr(5, 1'b1);
        latch();

        // Frame ending after 12 bits of a pixel.
        expect_px(0, 24'h0F0F0F);
        send_bits(24'h0F0F0F, 24, 1'b0);
        send_bits(24'hABC, 12, 1'b0);
        expect_fr(1, 1'b1);
        latch();

        // Reset in the middle of a pixel: no frame_done, then a clean frame.
        send_bits(24'hFFF, 12, 1'b0);
        din = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        din   = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        latch();
        expect_px(0, 24'h7E8191);
        send_bits(24'h7E8191, 24, 1'b0);
        expect_fr(1, 1'b0);
        latch();

        repeat (20) @(negedge clk);
        chk("pixels_outstanding", 64'(exp_px.size()), 64'd0);
        chk("frames_outstanding", 64'(exp_fr.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

WS2812 single-wire stream decoder: the receive end of the protocol our strip controller transmits. It samples the serial line and measures each high pulse to recover bits. Bits are assembled MSB-first into 24-bit pixel words, each tagged with its index in the frame, and the latch gap is reported as an end-of-frame event. It sits on the strip data line (looped back from `ws2812_dout`, or tapped from a chained strip). It provides on-board self-check of the pixel pipeline and a source for the LED-count/frame-rate diagnostics shown on `LED`.

## Interface
Parameters:
- `T_MIN_HIGH`, 15: minimum legal high time in clocks; shorter pulses are glitches.
- `T_THRESH`, 60: high time at or above this decodes as 1, below decodes as 0 (100 MHz: T0H≈40, T1H≈80).
- `T_MAX_HIGH`, 110: high time above this is an error.
- `T_RESET`, 5000: low time, in clocks, that constitutes a latch (50 µs).
- `PX_NUM`, 52: pixels per frame.
- `IDX_WIDTH`, 6: pixel index width.
- `BITS_PER_PIXEL`, 24: bits per pixel word.

Ports:
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-high reset.
- `din` in 1: raw WS2812 data line, asynchronous to `clk`.
- `pixel_data` out 24: last decoded pixel, first-received bit in [23].
- `pixel_index` out IDX_WIDTH: index of `pixel_data` within the frame (0..PX_NUM-1).
- `pixel_valid` out 1: one-cycle strobe; `pixel_data`/`pixel_index` are new.
- `frame_done` out 1: one-cycle strobe at latch detection.
- `frame_count` out IDX_WIDTH+1: pixels received in the frame just closed; valid while `frame_done`=1 and held until the next `frame_done`.
- `frame_err` out 1: error flag for the frame just closed; updated with `frame_done`.
- `busy` out 1: high while in HIGH or LOW state.

## Operation
- `din` passes through a 2-flop synchronizer giving `din_s`; a registered copy `din_d` gives `rise = din_s & ~din_d` and `fall = ~din_s & din_d`.
- Single counter `cnt` (13 bits, saturating at T_RESET) counts the cycles of the current level; it clears on every edge.
- States:
  - WAIT_LATCH (reset state): wait until `din_s` has been low for T_RESET cycles, then go to IDLE. A rise clears `cnt`, and the state stays WAIT_LATCH. This prevents decoding from mid-frame.
  - IDLE: on `rise`, go to HIGH. Clear `bit_cnt`, `pix_cnt` and the frame error.
  - HIGH: on `fall`, classify the pulse, then go to LOW.
    - If `cnt` < T_MIN_HIGH or > T_MAX_HIGH: set frame error, discard the partial pixel (`bit_cnt`←0), and shift nothing.
    - Otherwise shift in (`cnt` ≥ T_THRESH) and increment `bit_cnt`.
    - When `bit_cnt` reaches BITS_PER_PIXEL: if `pix_cnt` < PX_NUM, emit the pixel (`pixel_valid`, `pixel_index`=`pix_cnt`); otherwise set frame error and suppress the strobe. In both cases `pix_cnt`++ (saturating at PX_NUM+1) and `bit_cnt`←0.
    - If `cnt` exceeds T_MAX_HIGH while still high, the error is flagged at the fall; the state stays HIGH.
  - LOW: on `rise`, go to HIGH. When `cnt` reaches T_RESET, latch the frame and go to IDLE:
    - pulse `frame_done`;
    - `frame_count`←min(`pix_cnt`, PX_NUM);
    - `frame_err`←error | (`bit_cnt` ≠ 0).
- Bits arrive in strip order (G,R,B as transmitted); no reordering is done here.
- Reset values:
  - all strobes 0, `busy` 0;
  - `pixel_data` 0, `pixel_index` 0, `frame_count` 0, `frame_err` 0;
  - state WAIT_LATCH.
- Reset may assert mid-frame. The partial frame is discarded with no `frame_done`, and the decoder returns to WAIT_LATCH.

## Timing
- Synchronizer latency: 2 cycles; edge detect: +1. `pixel_valid` rises on the 3rd clock edge after the edge that first samples the final falling edge high→low.
- `frame_done` asserts T_RESET+3 cycles after the last falling edge reaches the `din` pin, ±1 cycle of sampling uncertainty.
- High-time resolution: ±1 cycle. Pulses of exactly T_THRESH decode as 1; exactly T_MIN_HIGH and exactly T_MAX_HIGH are legal.
- Inter-bit low gaps shorter than T_RESET, of any length, are tolerated.
- Minimum legal bit period is T_MIN_HIGH+2 cycles. Back-to-back pixels can strobe as close as 24×(T_MIN_HIGH+2) cycles apart; there is no backpressure.
- `pixel_valid` and `frame_done` never assert in the same cycle: the latch requires T_RESET low cycles after the final fall.

## Test plan
- Reset held, `din` toggling → all outputs 0, no strobes. Release with `din` high at 80 cycles per bit, no prior 5000-cycle low → no `pixel_valid` until a 5000-cycle low is seen.
- After latch: one pixel 0xA53C0F (bit 1 = 80 high/45 low; bit 0 = 40 high/85 low), then 5000 low. Required: `pixel_valid` once with `pixel_data`=0xA53C0F and `pixel_index`=0; then `frame_done` with `frame_count`=1 and `frame_err`=0.
- A 52-pixel frame with data = index×0x010203 → 52 strobes with matching data and indices 0..51; `frame_count`=52, `frame_err`=0. A 53rd pixel → no 53rd strobe, `frame_count`=52, `frame_err`=1.
- A 10-cycle high glitch inside pixel 3 → pixel 3 dropped, following pixels decode; `frame_err`=1 at latch.
- A frame ending after 12 bits of a pixel → no strobe for it; `frame_err`=1 at latch.
- Boundary pulses of 59/60 and 15/14/110/111 cycles → bits 0/1, with legal/error flags exactly as specified. Reset asserted mid-pixel → no `frame_done`, and the next full frame decodes cleanly.
